ysyx_24080014_rf_csr: RTL and testbench
=======================================

Name: ysyx_24080014_rf_csr

Overview:
Parametrised successor to the core's GPR/CSR storage: an NREG x XLEN integer register file with two read ports and optional write-to-read bypass, plus a machine-mode CSR unit. Supports CSRRW/CSRRS/CSRRC, a free-running 64-bit mcycle counter, and a trap/mret sequencer. The sequencer issues a one-cycle registered PC redirect to the fetch stage. Sits between decode/execute and writeback of the single-cycle NPC.

Parameters:
XLEN, 32, data width of GPRs and CSRs (32 only for mcycle/mcycleh split; other values are not supported).
NREG, 32, number of GPRs (16 for RV32E); AW = clog2(NREG).
BYPASS, 1, 1 = a same-cycle GPR write is forwarded to the read ports; 0 = reads return the stored value.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
wr_en  in  1  GPR write enable.
wr_addr  in  AW  GPR write index.
wr_data  in  XLEN  GPR write data.
rs1_addr  in  AW  read port 1 index.
rs2_addr  in  AW  read port 2 index.
rs1_data  out  XLEN  read port 1 data (combinational).
rs2_data  out  XLEN  read port 2 data (combinational).
csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
csr_addr  in  12  CSR address.
csr_wdata  in  XLEN  CSR operand (rs1 value or zimm).
csr_rdata  out  XLEN  old CSR value (combinational).
illegal_csr  out  1  csr_op!=0 and csr_addr is not implemented.
trap_req  in  1  ecall/exception request.
trap_cause  in  XLEN  value for mcause.
trap_pc  in  XLEN  PC of the trapping instruction.
mret_req  in  1  mret request.
redirect_valid  out  1  one-cycle pulse; fetch must take redirect_pc.
redirect_pc  out  XLEN  redirect target; 0 when redirect_valid=0.

Behaviour:
- Reset (rst_n=0 at an edge): all GPRs 0, mstatus=0x0000_1800, mtvec/mepc/mcause/mscratch 0, mcycle 0, state IDLE, redirect_valid 0, redirect_pc 0. Reset has priority over every other input.
- GPR: reads are combinational. Index 0 always reads 0; writes to index 0 are discarded. With BYPASS=1, if wr_en=1, wr_addr!=0 and wr_addr==rsN_addr, then rsN_data=wr_data. Each write commits at the edge.
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00 (low 32 bits), mcycleh 0xB80 (high 32 bits). Any other address: csr_rdata=0, illegal_csr=1, no write.
- CSR write value: RW writes csr_wdata; RS writes old|csr_wdata; RC writes old&~csr_wdata. RS/RC with csr_wdata==0 perform no write. mepc bits[1:0] and mtvec bit[1] are forced to 0 on write.
- mcycle: increments by 1 every cycle out of reset, with carry into mcycleh. A CSR write to either half wins over the increment for that cycle only; the other half holds its value.
- Sequencer states: IDLE, REDIR.
  - IDLE + trap_req: at the edge, mepc<=trap_pc&~3, mcause<=trap_cause, mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11. Next state REDIR with redirect_pc=mtvec&~3.
  - IDLE + mret_req (no trap_req): mstatus.MIE<=MPIE, MPIE<=1, MPP<=2'b11. Next state REDIR with redirect_pc=mepc. There is no +4; the handler advances mepc itself.
  - trap_req and mret_req together: trap wins. In any cycle where trap_req or mret_req is accepted, the CSR write is suppressed; GPR writes still commit.
  - REDIR: redirect_valid=1 for exactly one cycle, then IDLE. trap_req and mret_req are ignored while in REDIR; CSR and GPR accesses operate normally.
- Reset asserted in REDIR: return to IDLE, no pulse is emitted.

Test Plan:
- Reset, then write x5=0xDEADBEEF, write x0=0x1234 -> rs1(x5)=0xDEADBEEF, rs2(x0)=0; same-cycle write x7=0x55 with rs1_addr=7 -> rs1_data=0x55 (BYPASS=1), old value when BYPASS=0.
- CSRRW mtvec=0x8000_0102 -> next read 0x8000_0100. CSRRS mscratch 0x0F, then CSRRC 0x03 -> 0x0C. CSRRS with 0 -> no change, csr_rdata shows old value.
- csr_op=01, csr_addr=0x7C0 -> illegal_csr=1, csr_rdata=0, no state change.
- mtvec=0x8000_0100, mstatus.MIE=1, trap_req with pc=0x8000_0044, cause=11 -> mepc=0x8000_0044, mcause=11, mstatus=0x1880; next cycle redirect_valid=1 and redirect_pc=0x8000_0100 for one cycle.
- mret_req with mepc=0x8000_0048 -> redirect_pc=0x8000_0048, MIE=1, MPIE=1. trap_req+mret_req in the same cycle -> trap taken. A second trap_req during REDIR -> ignored.
- After reset, write mcycle=0xFFFF_FFFF -> following cycle mcycleh=1, mcycle=0. rst_n low during REDIR -> redirect_valid=0 at the next edge, all CSRs at reset values.

Source files
------------

// File: rtl/ysyx_24080014_rf_csr.sv
// Integer register file plus machine-mode CSR unit with a trap/mret redirect sequencer.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   wr_en/wr_addr/wr_data         GPR write port (x0 writes discarded)
//   rs1_addr/rs1_data             combinational read port 1
//   rs2_addr/rs2_data             combinational read port 2
//   csr_op/csr_addr/csr_wdata     CSRRW/CSRRS/CSRRC access
//   csr_rdata, illegal_csr        old CSR value, unimplemented-address flag
//   trap_req/trap_cause/trap_pc   trap entry request
//   mret_req                      trap return request
//   redirect_valid/redirect_pc    one-cycle registered PC redirect to fetch
module ysyx_24080014_rf_csr #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal_csr,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned MieBit  = 3;
    localparam int unsigned MpieBit = 7;

    typedef enum logic {StIdle, StRedir} state_e;

    // ---------------- GPR file ----------------
    logic [XLEN-1:0] gpr_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            gpr_q[wr_addr] <= wr_data;
        end
    end

    // rsN_addr != 0 together with the address match implies wr_addr != 0.
    always_comb begin
        rs1_data = gpr_q[rs1_addr];
        if (rs1_addr == '0) rs1_data = '0;
        else if (BYPASS && wr_en && wr_addr == rs1_addr) rs1_data = wr_data;
    end

    always_comb begin
        rs2_data = gpr_q[rs2_addr];
        if (rs2_addr == '0) rs2_data = '0;
        else if (BYPASS && wr_en && wr_addr == rs2_addr) rs2_data = wr_data;
    end

    // ---------------- CSR state ----------------
    logic [XLEN-1:0]   mstatus_q, mstatus_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d;
    logic [XLEN-1:0]   mscratch_q, mscratch_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;
    state_e            state_q, state_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;

    logic            csr_hit;
    logic [XLEN-1:0] csr_new;
    logic            csr_we;
    logic            take_trap;
    logic            take_mret;

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'hB00: csr_rdata = mcycle_q[XLEN-1:0];
            12'hB80: csr_rdata = mcycle_q[2*XLEN-1:XLEN];
            default: csr_hit   = 1'b0;
        endcase
    end

    assign illegal_csr = (csr_op != 2'b00) && !csr_hit;

    always_comb begin
        csr_new = csr_rdata;
        case (csr_op)
            2'b01:   csr_new = csr_wdata;
            2'b10:   csr_new = csr_rdata | csr_wdata;
            2'b11:   csr_new = csr_rdata & ~csr_wdata;
            default: csr_new = csr_rdata;
        endcase
    end

    // Requests are only accepted in IDLE; trap beats mret.
    assign take_trap = (state_q == StIdle) && trap_req;
    assign take_mret = (state_q == StIdle) && mret_req && !trap_req;

    // Set/clear with a zero operand is a pure read.
    assign csr_we = (csr_op != 2'b00) && csr_hit && !(csr_op[1] && csr_wdata == '0) &&
                    !take_trap && !take_mret;

    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 1'b1;
        state_d    = StIdle;
        redir_pc_d = redir_pc_q;

        if (take_trap) begin
            mepc_d             = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d           = trap_cause;
            mstatus_d[MpieBit] = mstatus_q[MieBit];
            mstatus_d[MieBit]  = 1'b0;
            mstatus_d[12:11]   = 2'b11;
            state_d            = StRedir;
            redir_pc_d         = {mtvec_q[XLEN-1:2], 2'b00};
        end else if (take_mret) begin
            mstatus_d[MieBit]  = mstatus_q[MpieBit];
            mstatus_d[MpieBit] = 1'b1;
            mstatus_d[12:11]   = 2'b11;
            state_d            = StRedir;
            redir_pc_d         = mepc_q;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: mstatus_d  = csr_new;
                12'h305: mtvec_d    = {csr_new[XLEN-1:2], 1'b0, csr_new[0]};
                12'h340: mscratch_d = csr_new;
                12'h341: mepc_d     = {csr_new[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = csr_new;
                // A write to one half freezes the other half for this cycle.
                12'hB00: mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], csr_new};
                12'hB80: mcycle_d   = {csr_new, mcycle_q[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= XLEN'(32'h0000_1800);
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            state_q    <= StIdle;
            redir_pc_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign redirect_valid = (state_q == StRedir);
    assign redirect_pc    = redirect_valid ? redir_pc_q : '0;

endmodule

// File: tb/tb_ysyx_24080014_rf_csr.sv
// Randomized and directed bench for ysyx_24080014_rf_csr against a behavioural model.
module tb_ysyx_24080014_rf_csr;

    localparam bit TbBypass = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        illegal_csr;
    logic        trap_req;
    logic [31:0] trap_cause, trap_pc;
    logic        mret_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_24080014_rf_csr #(
        .XLEN  (32),
        .NREG  (32),
        .BYPASS(TbBypass)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .illegal_csr   (illegal_csr),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .mret_req      (mret_req),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [32];
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle;
    bit          m_redir;
    logic [31:0] m_redir_pc;

    function automatic logic [31:0] m_csr(input logic [11:0] a, output bit ok);
        ok = 1'b1;
        case (a)
            12'h300: m_csr = m_mstatus;
            12'h305: m_csr = m_mtvec;
            12'h340: m_csr = m_mscratch;
            12'h341: m_csr = m_mepc;
            12'h342: m_csr = m_mcause;
            12'hB00: m_csr = m_mcycle[31:0];
            12'hB80: m_csr = m_mcycle[63:32];
            default: begin m_csr = 32'h0; ok = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) m_read = 32'h0;
        else if (TbBypass && wr_en && wr_addr == a) m_read = wr_data;
        else m_read = m_gpr[a];
    endfunction

    task automatic model_edge();
        bit ok;
        logic [31:0] old, nv;
        logic [63:0] next_cycle;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_mstatus = 32'h1800; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_mcycle = 64'h0; m_redir = 1'b0; m_redir_pc = 32'h0;
            return;
        end
        if (wr_en && wr_addr != 5'd0) m_gpr[wr_addr] = wr_data;
        next_cycle = m_mcycle + 64'd1;
        old = m_csr(csr_addr, ok);
        if (!m_redir && trap_req) begin
            m_mepc     = trap_pc & ~32'h3;
            m_mcause   = trap_cause;
            m_mstatus  = (m_mstatus & ~32'h88) | (m_mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
            m_redir    = 1'b1;
            m_redir_pc = m_mtvec & ~32'h3;
        end else if (!m_redir && mret_req) begin
            m_mstatus  = (m_mstatus & ~32'h8) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
            m_redir    = 1'b1;
            m_redir_pc = m_mepc;
        end else begin
            m_redir = 1'b0;
            if (csr_op != 2'b00 && ok && !(csr_op >= 2'b10 && csr_wdata == 32'h0)) begin
                nv = (csr_op == 2'b01) ? csr_wdata :
                     (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
                case (csr_addr)
                    12'h300: m_mstatus  = nv;
                    12'h305: m_mtvec    = nv & ~32'h2;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv & ~32'h3;
                    12'h342: m_mcause   = nv;
                    12'hB00: next_cycle = {m_mcycle[63:32], nv};
                    12'hB80: next_cycle = {nv, m_mcycle[31:0]};
                    default: ;
                endcase
            end
        end
        m_mcycle = next_cycle;
    endtask

    // Check combinational outputs against the model, then clock one edge.
    task automatic cycle(input bit chk);
        bit ok;
        logic [31:0] ec;
        #2;
        if (chk) begin
            ec = m_csr(csr_addr, ok);
            check("rs1_data", rs1_data, m_read(rs1_addr));
            check("rs2_data", rs2_data, m_read(rs2_addr));
            check("csr_rdata", csr_rdata, ec);
            check("illegal_csr", illegal_csr, (csr_op != 2'b00) && !ok);
            check("redirect_valid", redirect_valid, m_redir);
            check("redirect_pc", redirect_pc, m_redir ? m_redir_pc : 32'h0);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 0; wr_data = 0; rs1_addr = 0; rs2_addr = 0;
        csr_op = 0; csr_addr = 0; csr_wdata = 0; trap_req = 0; trap_cause = 0; trap_pc = 0;
        mret_req = 0;
    endtask

    task automatic csr_access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
        idle(); csr_op = op; csr_addr = a; csr_wdata = w;
    endtask

    logic [11:0] addr_tbl [9];

    initial begin
        addr_tbl = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'h7C0,
                     12'h301};
        idle(); rst_n = 1'b0;
        cycle(1'b0);
        cycle(1'b1);

        // GPR write, x0 discard, bypass
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; cycle(1'b1);
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 5; rs2_addr = 0;
        #2; check("x5", rs1_data, 32'hDEADBEEF); check("x0", rs2_data, 32'h0);
        cycle(1'b1);
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h55; rs1_addr = 7;
        #2; check("bypass_x7", rs1_data, TbBypass ? 32'h55 : 32'h0);
        cycle(1'b1);

        // CSR RW/RS/RC
        csr_access(2'b01, 12'h305, 32'h8000_0102); cycle(1'b1);
        csr_access(2'b00, 12'h305, 32'h0);
        #2; check("mtvec_mask", csr_rdata, 32'h8000_0100);
        cycle(1'b1);
        csr_access(2'b10, 12'h340, 32'h0F); cycle(1'b1);
        csr_access(2'b11, 12'h340, 32'h03); cycle(1'b1);
        csr_access(2'b10, 12'h340, 32'h00);
        #2; check("mscratch_rs0", csr_rdata, 32'h0C);
        cycle(1'b1);
        csr_access(2'b00, 12'h340, 32'h0);
        #2; check("mscratch_hold", csr_rdata, 32'h0C);
        cycle(1'b1);
        csr_access(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        #2; check("illegal", illegal_csr, 1'b1); check("illegal_rdata", csr_rdata, 32'h0);
        cycle(1'b1);

        // trap entry and ignored trap during REDIR
        csr_access(2'b10, 12'h300, 32'h8); cycle(1'b1);
        idle(); trap_req = 1; trap_pc = 32'h8000_0044; trap_cause = 11; cycle(1'b1);
        idle(); csr_addr = 12'h341; trap_req = 1; trap_pc = 32'h8000_0090; trap_cause = 5;
        #2; check("trap_valid", redirect_valid, 1'b1);
        check("trap_pc", redirect_pc, 32'h8000_0100); check("mepc", csr_rdata, 32'h8000_0044);
        cycle(1'b1);
        idle(); csr_addr = 12'h342;
        #2; check("pulse_end", redirect_valid, 1'b0); check("mcause", csr_rdata, 32'd11);
        cycle(1'b1);
        idle(); csr_addr = 12'h300;
        #2; check("mstatus_trap", csr_rdata, 32'h1880);
        cycle(1'b1);

        // mret
        csr_access(2'b01, 12'h341, 32'h8000_0048); cycle(1'b1);
        idle(); mret_req = 1; cycle(1'b1);
        idle(); csr_addr = 12'h300;
        #2; check("mret_pc", redirect_pc, 32'h8000_0048); check("mstatus_mret", csr_rdata, 32'h1888);
        cycle(1'b1);
        idle(); trap_req = 1; mret_req = 1; trap_pc = 32'h8000_0010; trap_cause = 2; cycle(1'b1);
        idle(); csr_addr = 12'h300;
        #2; check("both_pc", redirect_pc, 32'h8000_0100); check("both_mstatus", csr_rdata, 32'h1880);
        cycle(1'b1);

        // mcycle carry
        idle(); rst_n = 0; cycle(1'b1);
        csr_access(2'b01, 12'hB00, 32'hFFFF_FFFF); cycle(1'b1);
        idle(); csr_addr = 12'hB00; cycle(1'b1);
        idle(); csr_addr = 12'hB00;
        #2; check("mcycle_wrap", csr_rdata, 32'h0);
        cycle(1'b1);
        idle(); csr_addr = 12'hB80;
        #2; check("mcycleh_carry", csr_rdata, 32'h1);
        cycle(1'b1);

        // reset during REDIR
        csr_access(2'b01, 12'h305, 32'h4000_0000); cycle(1'b1);
        idle(); trap_req = 1; trap_pc = 32'h100; cycle(1'b1);
        idle(); rst_n = 0; cycle(1'b1);
        idle(); csr_addr = 12'h300;
        #2; check("rst_redir_valid", redirect_valid, 1'b0); check("rst_mstatus", csr_rdata, 32'h1800);
        cycle(1'b1);
        idle(); csr_addr = 12'h305;
        #2; check("rst_mtvec", csr_rdata, 32'h0);
        cycle(1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            rs1_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rs2_addr   = 5'($urandom_range(0, 31));
            csr_op     = 2'($urandom_range(0, 3));
            csr_addr   = addr_tbl[$urandom_range(0, 8)];
            csr_wdata  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            trap_req   = ($urandom_range(0, 15) == 0);
            mret_req   = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom;
            trap_pc    = $urandom;
            cycle(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
